// File: rtl/hci_bank_responder.sv
// rtl/hci_bank_responder.sv - HCI bank endpoint: grants requests, drives a 1-cycle SRAM, returns ordered responses.
// Optional out-of-range address check: HCI_BANK_RESPONDER_ADDR_CHECK_EN (adds bank_words_i).
module hci_bank_responder #(
    parameter int AW         = 10,
    parameter int DW         = 32,
    parameter int IW         = 8,
    parameter int UW         = 2,
    parameter int RESP_DEPTH = 2
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            clear_i,
    input  logic            req_i,
    output logic            gnt_o,
    input  logic [AW-1:0]   add_i,
    input  logic            wen_i,
    input  logic [DW/8-1:0] be_i,
    input  logic [DW-1:0]   data_i,
    input  logic [IW-1:0]   id_i,
    input  logic [UW-1:0]   user_i,
`ifdef HCI_BANK_RESPONDER_ADDR_CHECK_EN
    input  logic [AW:0]     bank_words_i,
`endif
    output logic            r_valid_o,
    input  logic            r_ready_i,
    output logic [DW-1:0]   r_data_o,
    output logic [IW-1:0]   r_id_o,
    output logic [UW-1:0]   r_user_o,
    output logic            r_opc_o,
    output logic            mem_req_o,
    output logic            mem_wen_o,
    output logic [AW-1:0]   mem_add_o,
    output logic [DW/8-1:0] mem_be_o,
    output logic [DW-1:0]   mem_wdata_o,
    input  logic [DW-1:0]   mem_rdata_i
);
    localparam int CW = $clog2(RESP_DEPTH + 1);
    localparam int PW = $clog2(RESP_DEPTH);

    typedef struct packed {
        logic [DW-1:0] data;
        logic [IW-1:0] id;
        logic [UW-1:0] user;
        logic          opc;
    } resp_t;

    resp_t           fifo_q [RESP_DEPTH];
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q, credits;
    logic            if_valid_q, if_wen_q, if_opc_q;
    logic [IW-1:0]   if_id_q;
    logic [UW-1:0]   if_user_q;
    logic            oob, empty, push, pop;
    resp_t           ft, head;

`ifdef HCI_BANK_RESPONDER_ADDR_CHECK_EN
    assign oob = ({1'b0, add_i} >= bank_words_i);
`else
    assign oob = 1'b0;
`endif

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(RESP_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Credits count every response that is buffered or still waiting on SRAM data.
    assign credits     = count_q + CW'(if_valid_q);
    assign gnt_o       = req_i & (credits < CW'(RESP_DEPTH)) & ~clear_i;
    assign mem_req_o   = gnt_o & ~oob;
    assign mem_wen_o   = wen_i;
    assign mem_add_o   = add_i;
    assign mem_be_o    = be_i;
    assign mem_wdata_o = data_i;

    always_comb begin
        ft = '0;
        if (if_valid_q) begin
            ft.data = (if_wen_q & ~if_opc_q) ? mem_rdata_i : '0;
            ft.id   = if_id_q;
            ft.user = if_user_q;
            ft.opc  = if_opc_q;
        end
    end

    assign empty = (count_q == '0);
    assign head  = empty ? ft : fifo_q[rd_ptr_q];
    // A fall-through response accepted in its own cycle never touches the FIFO.
    assign push  = if_valid_q & ~(empty & r_ready_i);
    assign pop   = ~empty & r_ready_i;

    assign r_valid_o = ~empty | if_valid_q;
    assign r_data_o  = head.data;
    assign r_id_o    = head.id;
    assign r_user_o  = head.user;
    assign r_opc_o   = head.opc;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            if_valid_q <= 1'b0;
            if_wen_q   <= 1'b0;
            if_opc_q   <= 1'b0;
            if_id_q    <= '0;
            if_user_q  <= '0;
        end else begin
            if_valid_q <= gnt_o;
            if (gnt_o) begin
                if_id_q   <= id_i;
                if_user_q <= user_i;
                if_wen_q  <= wen_i;
                if_opc_q  <= oob;
            end
            if (clear_i) begin
                count_q  <= '0;
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                count_q <= count_q + CW'(push) - CW'(pop);
                if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
                if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push && !clear_i) fifo_q[wr_ptr_q] <= ft;
    end
endmodule

// File: tb/tb_hci_bank_responder.sv
// tb/tb_hci_bank_responder.sv - scoreboard bench for hci_bank_responder with a 1-cycle SRAM model.
module tb_hci_bank_responder;
    logic        clk_i = 1'b0;
    logic        rst_ni, clear_i, req_i, gnt_o, wen_i, r_valid_o, r_ready_i, r_opc_o;
    logic [9:0]  add_i, mem_add_o;
    logic [3:0]  be_i, mem_be_o;
    logic [31:0] data_i, r_data_o, mem_wdata_o, mem_rdata_i;
    logic [7:0]  id_i, r_id_o;
    logic [1:0]  user_i, r_user_o;
    logic        mem_req_o, mem_wen_o;
`ifdef HCI_BANK_RESPONDER_ADDR_CHECK_EN
    logic [10:0] bank_words_i;
`endif

    hci_bank_responder dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i), .req_i(req_i), .gnt_o(gnt_o),
        .add_i(add_i), .wen_i(wen_i), .be_i(be_i), .data_i(data_i), .id_i(id_i), .user_i(user_i),
`ifdef HCI_BANK_RESPONDER_ADDR_CHECK_EN
        .bank_words_i(bank_words_i),
`endif
        .r_valid_o(r_valid_o), .r_ready_i(r_ready_i), .r_data_o(r_data_o), .r_id_o(r_id_o),
        .r_user_o(r_user_o), .r_opc_o(r_opc_o), .mem_req_o(mem_req_o), .mem_wen_o(mem_wen_o),
        .mem_add_o(mem_add_o), .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
    );

    initial forever #5 clk_i = ~clk_i;

    logic [31:0] mem [1024];
    always @(posedge clk_i) begin
        if (mem_req_o) begin
            if (mem_wen_o) mem_rdata_i <= mem[mem_add_o];
            else for (int b = 0; b < 4; b++) if (mem_be_o[b]) mem[mem_add_o][8*b +: 8] <= mem_wdata_o[8*b +: 8];
        end
    end

    typedef struct packed {
        logic [31:0] data;
        logic [7:0]  id;
        logic [1:0]  user;
        logic        opc;
    } exp_t;
    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: pops on every accepted response, and checks r_* stay frozen across stalls.
    logic stall_q = 1'b0;
    exp_t held;
    always @(negedge clk_i) begin
        if (rst_ni) begin
            if (stall_q) begin
                check("stall_valid", {63'b0, r_valid_o}, 64'd1);
                check("stall_data", {32'b0, r_data_o}, {32'b0, held.data});
                check("stall_id", {56'b0, r_id_o}, {56'b0, held.id});
            end
            if (r_valid_o && r_ready_i) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_resp", {56'b0, r_id_o}, 64'hDEAD);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("r_data", {32'b0, r_data_o}, {32'b0, e.data});
                    check("r_id", {56'b0, r_id_o}, {56'b0, e.id});
                    check("r_user", {62'b0, r_user_o}, {62'b0, e.user});
                    check("r_opc", {63'b0, r_opc_o}, {63'b0, e.opc});
                end
            end
            stall_q = r_valid_o && !r_ready_i && !clear_i;
            held = '{data: r_data_o, id: r_id_o, user: r_user_o, opc: r_opc_o};
        end else begin
            stall_q = 1'b0;
        end
    end

    // Holds req_i until granted (bounded); returns the number of cycles waited.
    task automatic issue(input logic wen, input logic [9:0] add, input logic [31:0] wdata,
                         input logic [7:0] id, input logic [1:0] user, input logic [31:0] exp_data,
                         input logic exp_opc, input logic exp_mreq, output int waited);
        bit done = 0;
        waited = 0;
        req_i = 1'b1; wen_i = wen; add_i = add; data_i = wdata; be_i = 4'hF; id_i = id; user_i = user;
        while (!done && waited < 50) begin
            @(negedge clk_i);
            if (gnt_o) begin
                exp_q.push_back('{data: exp_data, id: id, user: user, opc: exp_opc});
                check("mem_req", {63'b0, mem_req_o}, {63'b0, exp_mreq});
                done = 1;
            end
            @(posedge clk_i); #1;
            if (!done) waited++;
        end
        req_i = 1'b0;
        if (!done) check("grant_timeout", 64'd0, 64'd1);
    endtask

    task automatic drain();
        r_ready_i = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
            @(posedge clk_i); #1;
        end
        check("drained", exp_q.size(), 64'd0);
    endtask

    logic [31:0] wtab [8];
    int w;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem[5]   = 32'hCAFE0001;
        mem[255] = 32'h00FF1234;
        for (int i = 0; i < 8; i++) wtab[i] = 32'h13570000 + i * 32'h00001111;
        rst_ni = 1'b0; clear_i = 1'b0; req_i = 1'b0; wen_i = 1'b1; add_i = '0; be_i = '0;
        data_i = '0; id_i = '0; user_i = '0; r_ready_i = 1'b0;
`ifdef HCI_BANK_RESPONDER_ADDR_CHECK_EN
        bank_words_i = 11'd256;
`endif
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_r_valid", {63'b0, r_valid_o}, 64'd0);
        check("rst_gnt", {63'b0, gnt_o}, 64'd0);
        check("rst_mem_req", {63'b0, mem_req_o}, 64'd0);
        check("rst_r_data", {32'b0, r_data_o}, 64'd0);
        check("rst_r_opc", {63'b0, r_opc_o}, 64'd0);
        rst_ni = 1'b1;
        @(posedge clk_i); #1;

        // Single read: grant same cycle, response one cycle later.
        r_ready_i = 1'b1;
        issue(1'b1, 10'd5, 32'h0, 8'h3C, 2'd1, 32'hCAFE0001, 1'b0, 1'b1, w);
        check("single_wait", w, 64'd0);
        @(negedge clk_i);
        check("single_latency", {63'b0, r_valid_o}, 64'd1);
        @(posedge clk_i); #1;

        // Streaming writes then reads, one grant per cycle.
        for (int i = 0; i < 8; i++) begin
            issue(1'b0, 10'(16 + i), wtab[i], 8'(8'h10 + i), 2'(i), 32'h0, 1'b0, 1'b1, w);
            check("stream_wr_wait", w, 64'd0);
        end
        for (int i = 0; i < 8; i++) begin
            issue(1'b1, 10'(16 + i), 32'h0, 8'(8'h20 + i), 2'(i), wtab[i], 1'b0, 1'b1, w);
            check("stream_rd_wait", w, 64'd0);
        end
        drain();

        // Backpressure: two grants fill the credits, the third waits for a pop.
        r_ready_i = 1'b0;
        issue(1'b1, 10'd16, 32'h0, 8'h80, 2'd0, wtab[0], 1'b0, 1'b1, w);
        issue(1'b1, 10'd17, 32'h0, 8'h81, 2'd1, wtab[1], 1'b0, 1'b1, w);
        req_i = 1'b1; wen_i = 1'b1; add_i = 10'd18; id_i = 8'h82;
        repeat (3) begin
            @(negedge clk_i);
            check("bp_no_gnt", {63'b0, gnt_o}, 64'd0);
            @(posedge clk_i); #1;
        end
        r_ready_i = 1'b1;
        issue(1'b1, 10'd18, 32'h0, 8'h82, 2'd2, wtab[2], 1'b0, 1'b1, w);
        check("bp_credit_next_cycle", w, 64'd1);
        issue(1'b1, 10'd19, 32'h0, 8'h83, 2'd3, wtab[3], 1'b0, 1'b1, w);
        check("bp_after_pop", w, 64'd0);
        drain();

        // Alternating ready: simultaneous push/pop around full occupancy.
        for (int i = 0; i < 8; i++) begin
            r_ready_i = i[0];
            issue(1'b1, 10'(16 + i), 32'h0, 8'(8'h90 + i), 2'(i), wtab[i], 1'b0, 1'b1, w);
        end
        drain();

        // Clear with two responses buffered.
        r_ready_i = 1'b0;
        issue(1'b1, 10'd20, 32'h0, 8'hA0, 2'd0, wtab[4], 1'b0, 1'b1, w);
        issue(1'b1, 10'd21, 32'h0, 8'hA1, 2'd1, wtab[5], 1'b0, 1'b1, w);
        @(posedge clk_i); #1;
        clear_i = 1'b1; req_i = 1'b1; wen_i = 1'b1; add_i = 10'd22;
        @(negedge clk_i);
        check("clear_gnt", {63'b0, gnt_o}, 64'd0);
        exp_q.delete();
        @(posedge clk_i); #1;
        clear_i = 1'b0; req_i = 1'b0;
        @(negedge clk_i);
        check("clear_r_valid", {63'b0, r_valid_o}, 64'd0);
        @(posedge clk_i); #1;
        r_ready_i = 1'b1;
        issue(1'b1, 10'd22, 32'h0, 8'hB0, 2'd2, wtab[6], 1'b0, 1'b1, w);
        @(negedge clk_i);
        check("post_clear_latency", {63'b0, r_valid_o}, 64'd1);
        @(posedge clk_i); #1;
        drain();

`ifdef HCI_BANK_RESPONDER_ADDR_CHECK_EN
        issue(1'b1, 10'd300, 32'h0, 8'hC0, 2'd1, 32'h0, 1'b1, 1'b0, w);
        issue(1'b1, 10'd255, 32'h0, 8'hC1, 2'd2, 32'h00FF1234, 1'b0, 1'b1, w);
        drain();
`endif

        repeat (2) @(posedge clk_i);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
